tx_mac: RTL and testbench

Ethernet transmit MAC. Accepts frame bytes (dst/src/len/payload) from the TX asynch FIFO over AXI-Stream. Emits them to the RGMII PHY interface as preamble, SFD, payload, optional pad, FCS and inter-frame gap. Runs on the RGMII TX byte clock. All progress is gated by rgmii_mac_tx_rdy, which serves as the clock enable for 2.5/25/125 MHz link rates.

---
 rtl/eth_pkg.sv | 21 ++
 rtl/tx_mac_if.sv | 29 ++
 rtl/crc32.sv | 42 ++++
 rtl/tx_mac.sv | 168 ++++++++++++++++
 tb/tb_tx_mac.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and TX MAC state type.
// Used by tx_mac and the crc32 engine shared with the receiver.
package eth_pkg;

    localparam logic [7:0]  ETH_HDR      = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam int          PREAMBLE_LEN = 7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        DRAIN,
        IFG
    } tx_state_t;

endpackage

// File: rtl/tx_mac_if.sv
// AXI-Stream byte channel from the TX FIFO into the MAC.
// master drives frame bytes, slave returns trdy.
interface tx_mac_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  trdy;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  trdy
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output trdy
    );

endinterface

// File: rtl/crc32.sv
// Ethernet CRC-32 (reflected 0x04C11DB7), LSB-first per byte.
// crc_out is the inverted register, ready to put on the wire.
module crc32
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (crc_nxt[0] ^ data[i]) begin
                crc_nxt = (crc_nxt >> 1) ^ CRC_POLY;
            end else begin
                crc_nxt = crc_nxt >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else if (clr) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_nxt;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/tx_mac.sv
// Ethernet TX MAC: AXI-Stream bytes -> RGMII preamble/SFD/data/FCS/IFG.
// Build option TX_MAC_PAD_EN: zero-pad short frames up to MIN_FRAME_BYTES.
module tx_mac
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tx_mac_if.slave               s_tx_axis,
    output logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
    output logic                  rgmii_mac_tx_dv,
    output logic                  rgmii_mac_tx_er,
    input  logic                  rgmii_mac_tx_rdy
);

    if (DATA_WIDTH != 8 || IFG_BYTES < 2 || IFG_BYTES > 16 ||
        MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 65535) begin : g_bad_cfg
        $error("tx_mac: unsupported parameter set");
    end

    // IDLE spends one enabled cycle deciding, so IFG holds one less.
    localparam logic [3:0] IFG_LAST = 4'(IFG_BYTES - 2);
`ifdef TX_MAC_PAD_EN
    localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME_BYTES);
`endif

    tx_state_t             state_q, state_d;
    logic [2:0]            pre_q, pre_d;
    logic [3:0]            ifg_q, ifg_d;
    logic [1:0]            fcs_q, fcs_d;
    logic [15:0]           cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  dv_d, er_d;
    logic                  crc_en, crc_clr;
    logic [DATA_WIDTH-1:0] crc_din;
    logic [31:0]           crc_out;

    assign s_tx_axis.trdy = rgmii_mac_tx_rdy &&
                            (state_q == PAYLOAD || state_q == DRAIN);

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ifg_d   = '0;
        fcs_d   = '0;
        cnt_d   = cnt_q;
        data_d  = '0;
        dv_d    = 1'b0;
        er_d    = 1'b0;
        crc_en  = 1'b0;
        crc_clr = 1'b0;
        crc_din = s_tx_axis.tdata;
        unique case (state_q)
            IDLE: begin
                if (s_tx_axis.tvalid) begin
                    state_d = PREAMBLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end
            end
            PREAMBLE: begin
                dv_d  = 1'b1;
                pre_d = pre_q + 3'd1;
                if (pre_q == 3'(PREAMBLE_LEN)) begin
                    data_d  = ETH_SFD;
                    crc_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end else begin
                    data_d = ETH_HDR;
                end
            end
            PAYLOAD: begin
                dv_d = 1'b1;
                if (!s_tx_axis.tvalid) begin
                    er_d    = 1'b1;
                    state_d = DRAIN;
                end else begin
                    data_d = s_tx_axis.tdata;
                    er_d   = s_tx_axis.tuser;
                    crc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (s_tx_axis.tuser) begin
                        state_d = s_tx_axis.tlast ? IFG : DRAIN;
                    end else if (s_tx_axis.tlast) begin
`ifdef TX_MAC_PAD_EN
                        state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
`else
                        state_d = FCS;
`endif
                    end
                end
            end
`ifdef TX_MAC_PAD_EN
            PAD: begin
                dv_d    = 1'b1;
                crc_en  = 1'b1;
                crc_din = '0;
                cnt_d   = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    state_d = FCS;
                end
            end
`endif
            FCS: begin
                dv_d   = 1'b1;
                data_d = crc_out[{fcs_q, 3'b000} +: 8];
                fcs_d  = fcs_q + 2'd1;
                if (fcs_q == 2'd3) begin
                    state_d = IFG;
                end
            end
            DRAIN: begin
                if (s_tx_axis.tvalid && s_tx_axis.tlast) begin
                    state_d = IFG;
                end
            end
            IFG: begin
                ifg_d = ifg_q + 4'd1;
                if (ifg_q == IFG_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            pre_q             <= '0;
            ifg_q             <= '0;
            fcs_q             <= '0;
            cnt_q             <= '0;
            rgmii_mac_tx_data <= '0;
            rgmii_mac_tx_dv   <= 1'b0;
            rgmii_mac_tx_er   <= 1'b0;
        end else if (rgmii_mac_tx_rdy) begin
            state_q           <= state_d;
            pre_q             <= pre_d;
            ifg_q             <= ifg_d;
            fcs_q             <= fcs_d;
            cnt_q             <= cnt_d;
            rgmii_mac_tx_data <= data_d;
            rgmii_mac_tx_dv   <= dv_d;
            rgmii_mac_tx_er   <= er_d;
        end
    end

    crc32 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_crc32 (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (crc_clr && rgmii_mac_tx_rdy),
        .en     (crc_en && rgmii_mac_tx_rdy),
        .data   (crc_din),
        .crc_out(crc_out)
    );

endmodule

// File: tb/tb_tx_mac.sv
// Bench for tx_mac: random frames, rdy patterns, errors and reset,
// compared burst by burst against a frame-level model of the wire.
module tb_tx_mac;

    localparam int IFG = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rdy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_dv;
    logic       tx_er;

    tx_mac_if #(.DATA_WIDTH(8)) axis ();

    tx_mac dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_tx_axis        (axis),
        .rgmii_mac_tx_data(tx_data),
        .rgmii_mac_tx_dv  (tx_dv),
        .rgmii_mac_tx_er  (tx_er),
        .rgmii_mac_tx_rdy (rdy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // rdy patterns: 0 = always, 1 = one in ten, 2 = random
    int rdy_mode = 0;
    int div_cnt = 0;

    always @(negedge clk) begin
        case (rdy_mode)
            0: rdy = 1'b1;
            1: begin
                div_cnt = (div_cnt == 9) ? 0 : div_cnt + 1;
                rdy = (div_cnt == 0);
            end
            default: rdy = ($urandom_range(0, 2) != 0);
        endcase
    end

    // wire capture: {dv, er, data} for every enabled edge
    logic [9:0] wire_q[$];
    bit         mon_en = 1'b0;
    int         hold_err = 0;
    int         idle_run = 0;
    logic       mon_r;
    logic [9:0] cur;
    logic [9:0] last_out = '0;

    always @(posedge clk) begin
        mon_r = rdy;
        #1;
        cur = {tx_dv, tx_er, tx_data};
        if (mon_en && reset_n) begin
            if (mon_r) begin
                wire_q.push_back(cur);
                idle_run = tx_dv ? 0 : idle_run + 1;
            end else if (cur !== last_out) begin
                hold_err++;
            end
        end
        last_out = cur;
    end

    // reference model
    logic [31:0] crc_tab[256];
    logic [8:0]  exp_q[$];
    int          exp_len[$];
    int          exp_gap[$];
    logic [7:0]  fb[$];

    function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) c = crc_tab[(c[7:0] ^ b[i])] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic model(input logic [7:0] f[$], input int tuser_at,
                         input int under_at, output int drain);
        logic [7:0]  body[$];
        logic [31:0] c;
        int          n0;
        n0 = exp_q.size();
        drain = -1;
        repeat (7) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < f.size(); i++) begin
            if (i == under_at) begin
                exp_q.push_back(9'h100);
                drain = f.size() - i;
                break;
            end
            exp_q.push_back({i == tuser_at, f[i]});
            body.push_back(f[i]);
            if (i == tuser_at) begin
                drain = f.size() - 1 - i;
                break;
            end
        end
        if (drain < 0) begin
`ifdef TX_MAC_PAD_EN
            while (body.size() < 60) begin
                body.push_back(8'h00);
                exp_q.push_back(9'h000);
            end
`endif
            c = fcs_of(body);
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
            drain = 0;
        end
        exp_len.push_back(exp_q.size() - n0);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int tuser_at,
                              input int under_at, input int reset_at,
                              input int delay);
        int  idx;
        int  guard;
        bit  gap_done;
        idx = 0;
        guard = 0;
        gap_done = 1'b0;
        while (idx < f.size()) begin
            @(negedge clk);
            if (idx == reset_at) begin
                check("pre_reset_dv", 32'(tx_dv), 1);
                mon_en = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                check("rst_dv", 32'(tx_dv), 0);
                check("rst_er", 32'(tx_er), 0);
                check("rst_data", 32'(tx_data), 0);
                check("rst_trdy", 32'(axis.trdy), 0);
                axis.tvalid = 1'b0;
                axis.tlast  = 1'b0;
                axis.tuser  = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                wire_q.delete();
                mon_en = 1'b1;
                return;
            end
            if (idx == under_at && !gap_done) begin
                axis.tvalid = 1'b0;
            end else begin
                axis.tvalid = 1'b1;
                axis.tdata  = f[idx];
                axis.tlast  = (idx == f.size() - 1);
                axis.tuser  = (idx == tuser_at);
            end
            #1;
            if (axis.tvalid && axis.trdy) idx++;
            else if (!axis.tvalid && rdy) gap_done = 1'b1;
            guard++;
            if (guard > 20000) begin
                check("send_timeout", 32'(guard), 0);
                return;
            end
        end
        repeat (delay) begin
            @(negedge clk);
            axis.tvalid = 1'b0;
            axis.tlast  = 1'b0;
            axis.tuser  = 1'b0;
        end
    endtask

    task automatic do_frame(input int tuser_at, input int under_at,
                            input int delay);
        int drain;
        model(fb, tuser_at, under_at, drain);
        exp_gap.push_back(delay == 0 ? drain + IFG : -1);
        send_frame(fb, tuser_at, under_at, -1, delay);
    endtask

    task automatic rand_frame(input int len);
        fb.delete();
        repeat (len) fb.push_back(8'($urandom));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        idle_run = 0;
        while (idle_run < 20 && t < 30000) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("idle_wait", 32'(idle_run >= 20), 1);
    endtask

    task automatic check_stream(input string ph);
        int p, e, blen, gap, bad;
        p = 0;
        e = 0;
        while (p < wire_q.size() && !wire_q[p][9]) p++;
        for (int f = 0; f < exp_len.size(); f++) begin
            blen = 0;
            while (p < wire_q.size() && wire_q[p][9]) begin
                if (blen < exp_len[f])
                    check($sformatf("%s_f%0d_byte%0d", ph, f, blen),
                          32'(wire_q[p][8:0]), 32'(exp_q[e+blen]));
                blen++;
                p++;
            end
            check($sformatf("%s_f%0d_len", ph, f), blen, exp_len[f]);
            e += exp_len[f];
            gap = 0;
            bad = 0;
            while (p < wire_q.size() && !wire_q[p][9]) begin
                if (wire_q[p][8]) bad++;
                gap++;
                p++;
            end
            check($sformatf("%s_f%0d_gap_er", ph, f), bad, 0);
            if (f < exp_len.size() - 1) begin
                if (exp_gap[f] >= 0)
                    check($sformatf("%s_f%0d_gap", ph, f), gap, exp_gap[f]);
                else
                    check($sformatf("%s_f%0d_gap_min", ph, f),
                          32'(gap >= IFG), 1);
            end
        end
        check($sformatf("%s_extra_burst", ph), 32'(p < wire_q.size()), 0);
        wire_q.delete();
        exp_q.delete();
        exp_len.delete();
        exp_gap.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, tu, ua, sel;
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
            crc_tab[i] = c;
        end

        reset_n     = 1'b0;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", 32'(tx_data), 0);
        check("reset_dv", 32'(tx_dv), 0);
        check("reset_er", 32'(tx_er), 0);
        check("reset_trdy", 32'(axis.trdy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // continuous rdy, "123456789" then back-to-back random frames
        rdy_mode = 0;
        fb.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
        do_frame(-1, -1, 0);
        fb.delete();
        fb.push_back(8'hA5);
        do_frame(-1, -1, 0);
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(1, 80);
            rand_frame(len);
            do_frame(-1, -1, (k == 3) ? 2 : 0);
        end
        wait_idle();
        check_stream("rdy1");

        // 10 Mb/s strobe
        rdy_mode = 1;
        hold_err = 0;
        fb.delete();
        for (int i = 0; i < 64; i++) fb.push_back(8'(i));
        do_frame(-1, -1, 0);
        rand_frame($urandom_range(1, 30));
        do_frame(-1, -1, 2);
        wait_idle();
        check_stream("rdy10");
        check("hold_between_strobes", hold_err, 0);

        // random rdy with underrun and upstream errors
        rdy_mode = 2;
        rand_frame(40);
        do_frame(-1, 20, 0);
        fb.delete();
        for (int i = 0; i < 100; i++) fb.push_back(8'(i + 1));
        do_frame(29, -1, 0);
        rand_frame(10);
        do_frame(9, -1, 0);
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(2, 90);
            tu  = -1;
            ua  = -1;
            sel = $urandom_range(0, 2);
            rand_frame(len);
            if (sel == 1) tu = $urandom_range(0, len - 1);
            else if (sel == 2) ua = $urandom_range(1, len - 1);
            do_frame(tu, ua, (k == 7) ? 2 : 0);
        end
        wait_idle();
        check_stream("err");

        // reset mid-payload, then a clean frame
        rdy_mode = 0;
        rand_frame(40);
        send_frame(fb, -1, -1, 15, 1);
        rand_frame($urandom_range(5, 70));
        do_frame(-1, -1, 2);
        wait_idle();
        check_stream("rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
